// File: rtl/bin_erode_3x3.sv
// bin_erode_3x3 : streaming 3x3 binary erosion for the mask path.
//
// A pixel comes out white only when all nine taps of the window ending at
// that pixel are white. The window is anchored bottom-right: the result for
// stream position (r,c) covers rows r-2..r and columns c-2..c, and it is
// forced black for r<2 or c<2. Framing passes through a matched 2-cycle delay.
//
// Parameters
//   IMG_W  maximum active pixels per line (line-buffer depth)
//   CW     column counter width, 2^CW >= IMG_W
// Ports
//   sclk        pixel clock, rising edge
//   s_rst       synchronous active-high reset
//   vsync_i     frame sync in       -> vsync_o   (2-cycle delay)
//   hsync_i     line sync in        -> hsync_o   (2-cycle delay)
//   data_en_i   active pixel flag   -> data_en_o (2-cycle delay)
//   bin_data_i  mask pixel, bit 0 used (1 = white)
//   ero_data_o  16'hFFFF white / 16'h0000 black, aligned with data_en_o

// One column of the two-line buffer. Holds rows r-1 (lb1) and r-2 (lb2).
// No reset: row gating keeps stale contents from reaching the output.
module bin_erode_3x3_lb_cell (
    input  logic sclk,
    input  logic wr,
    input  logic px,
    output logic lb1,
    output logic lb2
);
    always_ff @(posedge sclk) begin
        if (wr) begin
            lb2 <= lb1;
            lb1 <= px;
        end
    end
endmodule

module bin_erode_3x3 #(
    parameter int IMG_W = 640,
    parameter int CW    = 10
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        vsync_i,
    input  logic        hsync_i,
    input  logic        data_en_i,
    input  logic [15:0] bin_data_i,
    output logic        vsync_o,
    output logic        hsync_o,
    output logic        data_en_o,
    output logic [15:0] ero_data_o
);
    localparam int STAGES = 2;
    // One extra bit so the counter can park at IMG_W once a line overruns.
    localparam int CCW = CW + 1;
    localparam logic [CCW-1:0] COL_END = CCW'(IMG_W);

    logic             de_d;
    logic             vs_d;
    logic             vs_rise;
    logic             de_fall;
    logic [CCW-1:0]   col;
    logic [CCW-1:0]   col_eff;
    logic [1:0]       row;
    logic [1:0]       row_eff;
    logic             in_rng;
    logic             px;

    logic [IMG_W-1:0] hit;
    logic [IMG_W-1:0] lb1;
    logic [IMG_W-1:0] lb2;
    logic             t1;
    logic             t2;

    // win[0] is the newest column; each column is {row r-2, row r-1, row r}.
    logic [2:0][2:0]  win;
    logic [2:0]       new_col;
    logic             win_ok;
    logic             res;

    logic [STAGES:1]  vld_pipe;
    logic [STAGES:1]  vs_pipe;
    logic [STAGES:1]  hs_pipe;

    logic             unused_hi;
    assign unused_hi = ^bin_data_i[15:1];

    assign px      = bin_data_i[0];
    assign vs_rise = vsync_i & ~vs_d;
    assign de_fall = de_d & ~data_en_i;

    // A vsync rise clears the counters before the same-cycle pixel uses them,
    // so a pixel coinciding with the rise lands at (0,0).
    assign col_eff = vs_rise ? '0 : col;
    assign row_eff = vs_rise ? '0 : row;
    assign in_rng  = (col_eff < COL_END);

    // Column-addressed buffer: one-hot decode, write on active pixels only.
    // An overrun column matches no cell, so it is neither written nor read.
    for (genvar i = 0; i < IMG_W; i++) begin : g_col
        assign hit[i] = (col_eff == CCW'(i));

        bin_erode_3x3_lb_cell u_cell (
            .sclk (sclk),
            .wr   (data_en_i & hit[i]),
            .px   (px),
            .lb1  (lb1[i]),
            .lb2  (lb2[i])
        );
    end

    assign t1      = |(lb1 & hit);
    assign t2      = |(lb2 & hit);
    assign new_col = {t2, t1, px};

    // Counters and edge detectors.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            de_d <= 1'b0;
            vs_d <= 1'b0;
            col  <= '0;
            row  <= '0;
        end else begin
            de_d <= data_en_i;
            vs_d <= vsync_i;

            if (data_en_i) begin
                col <= in_rng ? col_eff + CCW'(1) : col_eff;
            end else if (de_fall) begin
                col <= '0;
            end else begin
                col <= col_eff;
            end

            // Row saturates at 2: only "at least two lines above" matters.
            if (vs_rise) begin
                row <= '0;
            end else if (de_fall && row != 2'd2) begin
                row <= row + 2'd1;
            end
        end
    end

    // Stage 1: window shift and valid flag. Stage 2: gated 9-input AND.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            win      <= '0;
            win_ok   <= 1'b0;
            res      <= 1'b0;
            vld_pipe <= '0;
            vs_pipe  <= '0;
            hs_pipe  <= '0;
        end else begin
            if (data_en_i) begin
                win <= {win[1:0], new_col};
            end
            win_ok   <= data_en_i && (row_eff == 2'd2) &&
                        (col_eff >= CCW'(2)) && in_rng;
            res      <= win_ok & (&win);
            vld_pipe <= {vld_pipe[STAGES-1:1], data_en_i};
            vs_pipe  <= {vs_pipe[STAGES-1:1], vsync_i};
            hs_pipe  <= {hs_pipe[STAGES-1:1], hsync_i};
        end
    end

    assign vsync_o    = vs_pipe[STAGES];
    assign hsync_o    = hs_pipe[STAGES];
    assign data_en_o  = vld_pipe[STAGES];
    assign ero_data_o = (res && vld_pipe[STAGES]) ? 16'hFFFF : 16'h0000;

endmodule
